// File: rtl/node_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// node_pkg : shared types and defaults for the node round-robin arbiter
// Revision : 1.0
// ============================================================================
package node_pkg;

    localparam int NODE_WIDTH = 32;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage : node_pkg
`default_nettype wire

// File: rtl/node_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// node_rr_arbiter_if : N upstream valid/ready streams plus one downstream link
// Revision : 1.0
// ============================================================================
interface node_rr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32
);
    localparam int IW = $clog2(N);

    logic [N*WIDTH-1:0] data_in;
    logic [N-1:0]       last_in;
    logic [N-1:0]       valid_up_in;
    logic [N-1:0]       ready_up_out;
    logic [WIDTH-1:0]   data_out;
    logic               last_out;
    logic [IW-1:0]      grant_idx_out;
    logic               valid_down_out;
    logic               ready_down_in;

    // Arbiter side
    modport slave (
        input  data_in, last_in, valid_up_in, ready_down_in,
        output ready_up_out, data_out, last_out, grant_idx_out, valid_down_out
    );

    // Environment side (producers + consumer)
    modport master (
        output data_in, last_in, valid_up_in, ready_down_in,
        input  ready_up_out, data_out, last_out, grant_idx_out, valid_down_out
    );

endinterface : node_rr_arbiter_if
`default_nettype wire

// File: rtl/node_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational rotate-priority search starting at ptr
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  wire logic [N-1:0]  req,
    input  wire logic [IW-1:0] ptr,
    output logic               any,
    output logic [IW-1:0]      idx
);

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        int j;
        j   = 0;
        any = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/node_rr_arbiter.sv
`default_nettype none
// ============================================================================
// node_rr_arbiter : N-to-1 packet round-robin arbiter, one registered stage
// Revision : 1.0
// ============================================================================
module node_rr_arbiter
    import node_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = NODE_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    node_rr_arbiter_if.slave bus
);

    localparam int IW = $clog2(N);

    arb_state_e       r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_lock_idx;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic [IW-1:0]    r_gidx;
    logic             r_valid;

    logic             w_any;
    logic [IW-1:0]    w_pick_idx;
    logic [IW-1:0]    w_src;
    logic [IW-1:0]    w_next_ptr;
    logic             w_slot_free;
    logic             w_grant_en;
    logic             w_up_fire;
    logic             w_src_last;
    logic [N-1:0]     w_ready;
    logic [WIDTH-1:0] w_src_data;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (bus.valid_up_in),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick_idx)
    );

    assign w_slot_free = ~r_valid | bus.ready_down_in;
    assign w_src       = (r_state == LOCKED) ? r_lock_idx : w_pick_idx;
    // While locked the owner is offered the slot even if it has gone idle.
    assign w_grant_en  = (r_state == LOCKED) | w_any;
    assign w_next_ptr  = (w_src == IW'(N - 1)) ? '0 : w_src + IW'(1);

    always_comb begin
        w_ready    = '0;
        w_src_data = '0;
        w_src_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_src == IW'(i)) begin
                w_ready[i] = w_grant_en & w_slot_free;
                w_src_data = bus.data_in[i*WIDTH +: WIDTH];
                w_src_last = bus.last_in[i];
            end
        end
    end

    assign w_up_fire = |(w_ready & bus.valid_up_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB;
            r_ptr      <= '0;
            r_lock_idx <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_gidx     <= '0;
            r_valid    <= 1'b0;
        end else if (w_up_fire) begin
            r_data  <= w_src_data;
            r_last  <= w_src_last;
            r_gidx  <= w_src;
            r_valid <= 1'b1;
            if (w_src_last) begin
                r_ptr   <= w_next_ptr;
                r_state <= ARB;
            end else begin
                r_lock_idx <= w_src;
                r_state    <= LOCKED;
            end
        end else if (r_valid && bus.ready_down_in) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.ready_up_out   = w_ready;
    assign bus.data_out       = r_data;
    assign bus.last_out       = r_last;
    assign bus.grant_idx_out  = r_gidx;
    assign bus.valid_down_out = r_valid;

endmodule : node_rr_arbiter
`default_nettype wire

// File: tb/tb_node_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_node_rr_arbiter : directed + random stimulus against a packet-level model
// Revision : 1.0
// ============================================================================
module tb_node_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    node_rr_arbiter_if #(.N(N), .WIDTH(W)) bus ();

    node_rr_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: rotating pointer, optional packet owner, one-deep slot
    int          m_ptr;
    int          m_owner;
    bit          m_locked;
    bit          m_valid;
    bit          m_last;
    logic [31:0] m_data;
    int          m_gidx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_locked = 0;
        m_valid = 0; m_last = 0; m_data = '0; m_gidx = 0;
    endtask

    function automatic int winner(input logic [N-1:0] v);
        if (m_locked) return m_owner;
        for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, 64'(bus.valid_down_out), 64'(m_valid));
        chk({tag, "_data"},  64'(bus.data_out),       64'(m_data));
        chk({tag, "_last"},  64'(bus.last_out),       64'(m_last));
        chk({tag, "_gidx"},  64'(bus.grant_idx_out),  64'(m_gidx));
    endtask

    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic [N*W-1:0] d, input logic rdy, input string tag);
        int          w;
        bit          sf;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        bus.valid_up_in   = v;
        bus.last_in       = l;
        bus.data_in       = d;
        bus.ready_down_in = rdy;
        #1;
        w       = winner(v);
        sf      = !m_valid || rdy;
        exp_rdy = (w >= 0 && sf) ? N'(1 << w) : '0;
        chk({tag, "_ready"}, 64'(bus.ready_up_out), 64'(exp_rdy));
        @(posedge clk);
        if (w >= 0 && sf && v[w]) begin
            m_data  = d[w*W +: W];
            m_last  = l[w];
            m_gidx  = w;
            m_valid = 1;
            if (l[w]) begin m_ptr = (w + 1) % N; m_locked = 0; end
            else      begin m_owner = w;         m_locked = 1; end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.valid_up_in   = '0;
        bus.last_in       = '0;
        bus.data_in       = '0;
        bus.ready_down_in = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        chk("reset_ready", 64'(bus.ready_up_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness: every requester always has a single-beat packet
        for (int i = 0; i < 9; i++) begin
            cyc(4'hF, 4'hF, {32'h300 + i, 32'h200 + i, 32'h100 + i, 32'h000 + i}, 1'b1, "fair");
            chk("fair_seq", 64'(bus.grant_idx_out), 64'(i % 4));
        end

        // Lock: requester 2 sends A,B,C while requester 0 waits
        cyc(4'b0101, 4'b0001, {32'h0, 32'hA, 32'h0, 32'h50}, 1'b1, "lockA");
        chk("lock_r0_blocked", 64'(bus.ready_up_out[0]), 64'd0);
        cyc(4'b0101, 4'b0001, {32'h0, 32'hB, 32'h0, 32'h50}, 1'b1, "lockB");
        cyc(4'b0101, 4'b0101, {32'h0, 32'hC, 32'h0, 32'h50}, 1'b1, "lockC");
        chk("lock_C_src", 64'(bus.grant_idx_out), 64'd2);
        // Wrap: pointer now at 3 with only requester 0 valid
        cyc(4'b0001, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h0D}, 1'b1, "wrap");
        chk("wrap_src", 64'(bus.grant_idx_out), 64'd0);
        cyc(4'hF, 4'hF, {32'h3E, 32'h2E, 32'h1E, 32'h0E}, 1'b1, "wrap_next");
        chk("wrap_ptr1", 64'(bus.grant_idx_out), 64'd1);

        // Backpressure with 0xAA held in the slot
        cyc(4'b1000, 4'b1000, {32'hAA, 96'h0}, 1'b1, "bp_load");
        for (int i = 0; i < 5; i++) begin
            cyc(4'hF, 4'hF, {32'h3F, 32'h2F, 32'h1F, 32'h0F}, 1'b0, "bp_hold");
            chk("bp_data", 64'(bus.data_out), 64'hAA);
        end
        cyc(4'h0, 4'h0, '0, 1'b1, "bp_drain");
        chk("bp_drained", 64'(bus.valid_down_out), 64'd0);

        // Bubble mid-packet on requester 1 with requester 3 waiting
        cyc(4'b1010, 4'b1000, {32'h33, 32'h0, 32'h11, 32'h0}, 1'b1, "bub_first");
        for (int i = 0; i < 3; i++)
            cyc(4'b1000, 4'b1000, {32'h33, 96'h0}, 1'b1, "bub_idle");
        cyc(4'b1010, 4'b1010, {32'h33, 32'h0, 32'h22, 32'h0}, 1'b1, "bub_last");
        chk("bub_data", 64'(bus.data_out), 64'h22);
        cyc(4'b1000, 4'b1000, {32'h33, 96'h0}, 1'b1, "bub_r3");
        chk("bub_r3_src", 64'(bus.grant_idx_out), 64'd3);

        // Random traffic
        for (int i = 0; i < 300; i++)
            cyc(N'($urandom), N'($urandom),
                {$urandom, $urandom, $urandom, $urandom},
                ($urandom_range(0, 3) != 0), "rand");

        // Flush any open packet, then lock on requester 2 and reset mid-packet
        for (int i = 0; i < 4; i++)
            cyc(4'hF, 4'hF, {32'h3, 32'h2, 32'h1, 32'h0}, 1'b1, "flush");
        cyc(4'b0100, 4'b0000, {32'h0, 32'h77, 64'h0}, 1'b1, "rst_lock0");
        cyc(4'b0100, 4'b0000, {32'h0, 32'h78, 64'h0}, 1'b1, "rst_lock1");
        @(negedge clk);
        bus.valid_up_in = '0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst_ready", 64'(bus.ready_up_out), 64'd0);
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b0101, 4'b0101, {32'h0, 32'h2A, 32'h0, 32'h0A}, 1'b1, "post_rst");
        chk("post_rst_src", 64'(bus.grant_idx_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_node_rr_arbiter
`default_nettype wire

// File: doc/node_rr_arbiter.md
# node_rr_arbiter

N-to-1 round-robin arbiter for valid/ready node chains. It merges N upstream packet streams onto one downstream link and holds each grant until the packet's last beat. It has one registered output stage, gives full throughput, and sits between several producer nodes and a shared consumer node.

## Interface
- WIDTH, 32, data width per beat
- N, 4, number of requesters (2..16); IW = $clog2(N)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  N*WIDTH  requester i beat at [i*WIDTH +: WIDTH]
- last_in  in  N  requester i beat is the final beat of its packet
- valid_up_in  in  N  requester i beat valid
- ready_up_out  out  N  beat accepted from requester i (at most one bit set)
- data_out  out  WIDTH  registered beat to downstream
- last_out  out  1  registered last flag
- grant_idx_out  out  IW  source index of the beat on data_out
- valid_down_out  out  1  registered output valid
- ready_down_in  in  1  downstream ready

## Operation
- Definitions:
  - slot_free = !valid_down_out | ready_down_in
  - up_fire_i = valid_up_in[i] & ready_up_out[i]
  - down_fire = valid_down_out & ready_down_in
- State ARB (reset state):
  - winner = first i with valid_up_in[i] set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - ready_up_out[winner] = slot_free. All other ready_up_out bits are 0. All bits are 0 when no requester is valid.
- ARB transitions on up_fire:
  - last_in[winner]=1: ptr <= winner+1 mod N; stay in ARB.
  - last_in[winner]=0: lock_idx <= winner; go to LOCKED. ptr is unchanged.
- State LOCKED:
  - ready_up_out[lock_idx] = slot_free, independent of valid. All other ready_up_out bits are 0.
  - Other requesters are ignored even when valid.
  - On up_fire with last_in[lock_idx]=1: ptr <= lock_idx+1 mod N; go to ARB.
- Output register, on any up_fire:
  - data_out <= data_in[src]; last_out <= last_in[src]; grant_idx_out <= src; valid_down_out <= 1.
- Output register, otherwise:
  - down_fire: valid_down_out <= 0.
  - No down_fire: data_out, last_out and grant_idx_out hold their values.
- Requester valid_up_in may deassert mid-packet while LOCKED. The lock persists and the link idles.
- Reset value of every output register is 0: data_out, last_out, grant_idx_out, valid_down_out. ptr, lock_idx and state also reset (ptr=0, lock_idx=0, state=ARB). ready_up_out is therefore all 0 out of reset until a requester is valid.

## Timing
- Latency: a beat accepted at edge k appears on data_out with valid_down_out=1 from k+1.
- Throughput: 1 beat per cycle when ready_down_in is held high, including packet-to-packet switches between requesters.
- Accept and drain in the same cycle are allowed. The new beat overwrites the slot and valid stays 1.
- valid_down_out never drops without down_fire.
- data_out, last_out and grant_idx_out are stable while valid_down_out=1 and ready_down_in=0.
- ready_up_out is combinational:
  - from ready_down_in, valid_down_out, state and ptr;
  - from valid_up_in, in ARB only.
- Upstream ready depending on upstream valid is permitted for this block.
- ptr wraps from N-1 to 0.
- Asserting rst_n=0 mid-packet clears the lock and the output slot immediately. The in-flight beat is lost, and arbitration restarts at requester 0.

## Structure
- Package node_pkg:
  - localparam default WIDTH=32.
  - typedef enum logic {ARB, LOCKED} arb_state_e.
- Sub-module rr_pick #(N): purely combinational rotate-priority search.
  - Inputs: req[N], ptr[IW].
  - Outputs: any, idx[IW].
  - Reused by later schedulers.
- Top-level node_rr_arbiter holds the FSM, ptr, lock_idx, the output register and the source mux.

## Test plan
- Fairness: N=4; all four requesters send continuous single-beat packets (last=1) and ready_down_in=1. Expected grant_idx_out sequence is 0,1,2,3,0,1,… with valid_down_out high every cycle after the first.
- Lock: requester 2 sends a 3-beat packet (data A,B,C, last on C) while requester 0 is valid throughout. Expected output is A,B,C from source 2, then requester 0 next. ready_up_out[0]=0 during A..C.
- Backpressure: hold ready_down_in=0 for 5 cycles with one beat D=0x0000_00AA held. Expected data_out=0xAA and valid_down_out=1 stable for all 5 cycles, with ready_up_out all 0. Release ready_down_in and D drains in 1 cycle.
- Bubble mid-packet: requester 1 sends beat 0x11 (last=0), drops valid for 3 cycles, then sends 0x22 (last=1) while requester 3 is valid. Expected output 0x11 then 0x22 from source 1, then requester 3 granted.
- Wrap: N=4 with ptr reaching 3 and only requester 0 valid. Expected requester 0 granted and ptr then equal to 1.
- Reset mid-packet: assert rst_n=0 during LOCKED on requester 2. Expected all outputs 0 asynchronously and state ARB. After release, requester 0 wins over requester 2 when both are valid.
